multi_cycle_cu: RTL
===================

# multi_cycle_cu

Multi-cycle control unit that sequences the shared RV64 datapath (PC, instruction register, register file, ALU, data memory) over several cycles per instruction instead of one. It walks a FETCH/DECODE/EXEC/MEM/WB state machine, inserts wait states on instruction- and data-memory ready handshakes, and pulses PC and register-file write enables exactly once per retired instruction. It traps on illegal opcodes and on data-memory timeouts. It supports R-type (0110011), load (0000011), store (0100011) and branch-if-equal (1100011).

## Interface
- `WAIT_MAX`, default 15: maximum consecutive MEM cycles without `dmem_ready` before a timeout trap.
- `CNT_W`, default 32: width of the performance counters.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `imem_ready` in 1: instruction memory data valid this cycle.
- `dmem_ready` in 1: data memory access completes this cycle.
- `opcode` in 7: instruction register bits [6:0].
- `zero` in 1: ALU zero flag.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: update the PC.
- `pc_src` out 1: PC source select; 0 selects PC+4, 1 selects the branch target.
- `reg_write` out 1: register file write enable.
- `ALUSrc` out 1: ALU operand-2 select; 1 selects the immediate.
- `MemToReg` out 1: writeback select; 1 selects memory read data.
- `Mem_Read`, `Mem_Write` out 1 each: data memory strobes.
- `ALU_Op` out 2: to `alu_control`; 00 add, 01 sub/compare, 10 funct-decoded.
- `retire` out 1: one-cycle pulse per completed instruction.
- `trap` out 1: sticky error flag.
- `trap_cause` out 2: 01 illegal opcode, 10 dmem timeout.
- `state` out 3: current state, for debug.
- `cycle_cnt`, `instret_cnt` out `CNT_W` each: performance counters.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Codes 5 and 6 go to TRAP with cause 01.
- Outputs are a combinational decode of the state, the latched class and the ready inputs. Any output not listed for a state is 0.
- **FETCH:** wait while `imem_ready`=0. On `imem_ready`=1, assert `ir_write` and go to DECODE.
- **DECODE:** latch the opcode into an internal class register (R/LD/ST/BR).
  - Legal opcode: go to EXEC.
  - Otherwise: go to TRAP with cause 01.
- **EXEC:**
  - R: `ALU_Op`=10; go to WB.
  - LD/ST: `ALUSrc`=1, `ALU_Op`=00; go to MEM and clear the wait counter.
  - BR: `ALU_Op`=01, `pc_write`=1, `pc_src`=`zero`, `retire`=1; go to FETCH.
- **MEM:** hold `ALUSrc`=1 and `ALU_Op`=00. Hold `Mem_Read` (LD) or `Mem_Write` (ST) high until `dmem_ready`.
  - On `dmem_ready`=1, assert `pc_write`=1, `retire`=1 and go to FETCH. For LD also assert `reg_write`=1 and `MemToReg`=1 in that same cycle.
  - Each MEM cycle with `dmem_ready`=0 increments the wait counter. When the counter reaches `WAIT_MAX`, go to TRAP with cause 10 instead of waiting further.
- **WB (R only):** `reg_write`=1, `pc_write`=1, `pc_src`=0, `retire`=1; go to FETCH.
- **TRAP:** all strobes 0, `trap`=1, `trap_cause` held. Only reset leaves TRAP.
- `ir_write`, `pc_write`, `reg_write` and `retire` each assert for exactly one cycle per instruction (`ir_write` at fetch, the others at completion). `Mem_Write` never overlaps `reg_write`.

## Timing
- Reset: while `rst_n`=0 at a rising edge:
  - `state` goes to FETCH.
  - The class register, wait counter, `trap`, `trap_cause` and counters clear.
  - All outputs are forced to 0 during the reset cycle, regardless of the ready inputs.
- Latency with zero-wait memories:
  - Branch: 3 cycles.
  - R-type: 4 cycles.
  - Load: 4 cycles.
  - Store: 4 cycles.
- Each cycle with `imem_ready` or `dmem_ready` low adds one cycle.
- A ready input sampled high in a state where it is not awaited has no effect.
- Reset asserted mid-instruction aborts it: no `pc_write` and no `reg_write` are issued, and the next edge is in FETCH.
- `dmem_ready` arriving in the same cycle the wait counter reaches `WAIT_MAX`: completion wins and no trap is taken.
- `zero` is sampled only in the EXEC cycle of a branch.

## Configuration
- `MULTI_CYCLE_CU_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every non-reset cycle outside TRAP.
  - `instret_cnt` increments on each `retire`.
  - Both wrap modulo 2^`CNT_W`.
- `MULTI_CYCLE_CU_PERF_CNT_EN` undefined: both ports remain present, are tied to 0, and no counter flops are synthesized.

## Test plan
- R-type, both readies held high: reset, `opcode`=0110011 → states 0,1,2,4. `reg_write`=1 and `pc_write`=1 only in cycle 4, one `retire` pulse, then FETCH.
- Load with `dmem_ready` low for 3 cycles: `Mem_Read` high for 4 MEM cycles. On the final cycle `reg_write`=`MemToReg`=`pc_write`=1. Total 7 cycles.
- Branch: with `zero`=1, `pc_src`=1 in cycle 3; with `zero`=0, `pc_src`=0. Branches never assert `reg_write`.
- Store with `dmem_ready` stuck low, `WAIT_MAX`=15: after 15 MEM cycles, `state`=7, `trap`=1, `trap_cause`=10, no `pc_write`. Stays in TRAP until `rst_n`=0.
- Illegal opcode 0010011 → TRAP with cause 01 after DECODE. Reset asserted during a load's MEM wait → FETCH next cycle with no writes issued.
- With the macro defined, 10 back-to-back R-type instructions from reset → `instret_cnt`=10 and `cycle_cnt`=40.

Source files
------------

// File: rtl/multi_cycle_cu_if.sv
// Control-unit <-> datapath/memory bus: ready handshakes, opcode/flags in,
// datapath strobes, trap status, state and performance counters out.
interface multi_cycle_cu_if #(
  parameter int CNT_W = 32
);
  logic             imem_ready;
  logic             dmem_ready;
  logic [6:0]       opcode;
  logic             zero;

  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             reg_write;
  logic             ALUSrc;
  logic             MemToReg;
  logic             Mem_Read;
  logic             Mem_Write;
  logic [1:0]       ALU_Op;
  logic             retire;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  // Control unit side
  modport master (
    input  imem_ready, dmem_ready, opcode, zero,
    output ir_write, pc_write, pc_src, reg_write, ALUSrc, MemToReg,
           Mem_Read, Mem_Write, ALU_Op, retire, trap, trap_cause, state,
           cycle_cnt, instret_cnt
  );

  // Datapath / memory side
  modport slave (
    output imem_ready, dmem_ready, opcode, zero,
    input  ir_write, pc_write, pc_src, reg_write, ALUSrc, MemToReg,
           Mem_Read, Mem_Write, ALU_Op, retire, trap, trap_cause, state,
           cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multi_cycle_cu.sv
// Multi-cycle RV64 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with traps.
// Optional performance counters enabled by MULTI_CYCLE_CU_PERF_CNT_EN.
module multi_cycle_cu #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  multi_cycle_cu_if.master bus
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_RSV5   = 3'd5,
    S_RSV6   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [1:0] {CL_R, CL_LD, CL_ST, CL_BR} cls_t;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       retire;
  } ctrl_t;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TO  = 2'b10;

  state_t          state_q, state_d;
  cls_t            cls_q, cls_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [1:0]      cause_q, cause_d;
  ctrl_t           ctl;
  cls_t            dec_cls;
  logic            dec_legal;

  always_comb begin
    dec_cls   = CL_R;
    dec_legal = 1'b1;
    case (bus.opcode)
      OP_R:    dec_cls = CL_R;
      OP_LD:   dec_cls = CL_LD;
      OP_ST:   dec_cls = CL_ST;
      OP_BR:   dec_cls = CL_BR;
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= CL_R;
      wait_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    wait_d  = wait_q;
    cause_d = cause_q;
    ctl     = '0;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ready) begin
          ctl.ir_write = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end
      end
      S_EXEC: begin
        case (cls_q)
          CL_R: begin
            ctl.alu_op = 2'b10;
            state_d    = S_WB;
          end
          CL_LD, CL_ST: begin
            ctl.alu_src = 1'b1;
            ctl.alu_op  = 2'b00;
            wait_d      = '0;
            state_d     = S_MEM;
          end
          default: begin
            // Branch resolves here; zero is only looked at in this cycle.
            ctl.alu_op   = 2'b01;
            ctl.pc_write = 1'b1;
            ctl.pc_src   = bus.zero;
            ctl.retire   = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        ctl.alu_src   = 1'b1;
        ctl.alu_op    = 2'b00;
        ctl.mem_read  = (cls_q == CL_LD);
        ctl.mem_write = (cls_q == CL_ST);
        if (bus.dmem_ready) begin
          // Completion takes priority over a timeout reached this same cycle.
          ctl.pc_write   = 1'b1;
          ctl.retire     = 1'b1;
          ctl.reg_write  = (cls_q == CL_LD);
          ctl.mem_to_reg = (cls_q == CL_LD);
          state_d        = S_FETCH;
        end else begin
          wait_d = wait_q + WW'(1);
          if (wait_q == WAIT_LAST) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TO;
          end
        end
      end
      S_WB: begin
        ctl.reg_write = 1'b1;
        ctl.pc_write  = 1'b1;
        ctl.pc_src    = 1'b0;
        ctl.retire    = 1'b1;
        state_d       = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
        cause_d = CAUSE_ILL;
      end
    endcase
  end

  // Every output is held low while reset is asserted, whatever the inputs do.
  assign bus.ir_write   = rst_n & ctl.ir_write;
  assign bus.pc_write   = rst_n & ctl.pc_write;
  assign bus.pc_src     = rst_n & ctl.pc_src;
  assign bus.reg_write  = rst_n & ctl.reg_write;
  assign bus.ALUSrc     = rst_n & ctl.alu_src;
  assign bus.MemToReg   = rst_n & ctl.mem_to_reg;
  assign bus.Mem_Read   = rst_n & ctl.mem_read;
  assign bus.Mem_Write  = rst_n & ctl.mem_write;
  assign bus.ALU_Op     = rst_n ? ctl.alu_op : 2'b00;
  assign bus.retire     = rst_n & ctl.retire;
  assign bus.trap       = rst_n & (state_q == S_TRAP);
  assign bus.trap_cause = rst_n ? cause_q : 2'b00;
  assign bus.state      = rst_n ? state_q : S_FETCH;

`ifdef MULTI_CYCLE_CU_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ins_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state_q != S_TRAP) cyc_q <= cyc_q + CNT_W'(1);
      if (ctl.retire)        ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign bus.cycle_cnt   = rst_n ? cyc_q : {CNT_W{1'b0}};
  assign bus.instret_cnt = rst_n ? ins_q : {CNT_W{1'b0}};
`else
  assign bus.cycle_cnt   = {CNT_W{1'b0}};
  assign bus.instret_cnt = {CNT_W{1'b0}};
`endif

endmodule
